// File: rtl/toy_mem_arbiter.sv
// toy_mem_arbiter: round-robin arbiter sharing one memory port
// among REQ_NUM requesters, each with a one-deep response slot.
module toy_mem_arbiter #(
   parameter int REQ_NUM    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [REQ_NUM-1:0]              req_valid,
   output logic [REQ_NUM-1:0]              req_ready,
   input  logic [REQ_NUM*ADDR_WIDTH-1:0]   req_addr,
   input  logic [REQ_NUM-1:0]              req_wr_en,
   input  logic [REQ_NUM*DATA_WIDTH-1:0]   req_wr_data,
   input  logic [REQ_NUM*DATA_WIDTH/8-1:0] req_wr_byte_en,
   output logic [REQ_NUM-1:0]              resp_valid,
   input  logic [REQ_NUM-1:0]              resp_ready,
   output logic [REQ_NUM*DATA_WIDTH-1:0]   resp_data,
   output logic                            mem_en,
   output logic                            mem_wr_en,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_wr_data,
   output logic [DATA_WIDTH/8-1:0]         mem_wr_byte_en,
   input  logic [DATA_WIDTH-1:0]           mem_rd_data
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int IW = $clog2(REQ_NUM);

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      INFLIGHT = 2'd1,
      FULL     = 2'd2
   } slot_t;

   slot_t                 slot_st   [REQ_NUM];
   logic [REQ_NUM-1:0]    slot_wr;
   logic [DATA_WIDTH-1:0] slot_data [REQ_NUM];
   logic [IW-1:0]         last_grant;

   logic [REQ_NUM-1:0]    elig;
   logic                  grant;
   logic [IW-1:0]         gidx;

   // A requester may issue when its slot will be free at the next edge
   always_comb begin
      elig = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         elig[i] = rst_n && req_valid[i] &&
                   (slot_st[i] == EMPTY ||
                    (slot_st[i] == INFLIGHT && resp_ready[i]));
      end
   end

   // Round-robin pick starting one past the last winner
   always_comb begin
      logic [IW-1:0] cand;
      grant = 1'b0;
      gidx  = '0;
      cand  = '0;
      for (int k = 1; k <= REQ_NUM; k++) begin
         cand = IW'((int'(last_grant) + k) % REQ_NUM);
         if (!grant && elig[cand]) begin
            grant = 1'b1;
            gidx  = cand;
         end
      end
   end

   // One-hot grant and memory port mux from the winner
   always_comb begin
      req_ready      = '0;
      mem_en         = grant;
      mem_wr_en      = 1'b0;
      mem_addr       = '0;
      mem_wr_data    = '0;
      mem_wr_byte_en = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         if (grant && gidx == IW'(i)) begin
            req_ready[i]   = 1'b1;
            mem_wr_en      = req_wr_en[i];
            mem_addr       = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wr_data    = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            mem_wr_byte_en = req_wr_byte_en[i*BW +: BW];
         end
      end
   end

   // Response outputs decoded from slot state
   always_comb begin
      resp_valid = '0;
      resp_data  = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         resp_valid[i] = slot_st[i] != EMPTY;
         unique case (1'b1)
            (slot_st[i] == FULL):
               resp_data[i*DATA_WIDTH +: DATA_WIDTH] = slot_data[i];
            (slot_st[i] == INFLIGHT && !slot_wr[i]):
               resp_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data;
            default:
               resp_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         endcase
      end
   end

   // Slot state machines and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= IW'(REQ_NUM - 1);
         slot_wr    <= '0;
         for (int i = 0; i < REQ_NUM; i++) begin
            slot_st[i]   <= EMPTY;
            slot_data[i] <= '0;
         end
      end else begin
         if (grant) last_grant <= gidx;
         for (int i = 0; i < REQ_NUM; i++) begin
            case (slot_st[i])
               EMPTY: begin
                  if (req_ready[i]) begin
                     slot_st[i] <= INFLIGHT;
                     slot_wr[i] <= req_wr_en[i];
                  end
               end
               INFLIGHT: begin
                  if (req_ready[i]) begin
                     slot_wr[i] <= req_wr_en[i];
                  end else if (resp_ready[i]) begin
                     slot_st[i] <= EMPTY;
                  end else begin
                     slot_st[i]   <= FULL;
                     slot_data[i] <=
                        slot_wr[i] ? '0 : mem_rd_data;
                  end
               end
               FULL: begin
                  if (resp_ready[i]) slot_st[i] <= EMPTY;
               end
               default: slot_st[i] <= EMPTY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// tb_toy_mem_arbiter: scoreboard bench for toy_mem_arbiter
// with a behavioural byte-enabled memory behind the port.
module tb_toy_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_addr;
   logic [1:0]  req_wr_en;
   logic [63:0] req_wr_data;
   logic [7:0]  req_wr_byte_en;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [63:0] resp_data;
   logic        mem_en;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wr_byte_en;
   logic [31:0] mem_rd_data = '0;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] sim_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic [1:0]  lat_due = '0;
   logic        mon_on  = 1'b0;

   toy_mem_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_wr_en      (req_wr_en),
      .req_wr_data    (req_wr_data),
      .req_wr_byte_en (req_wr_byte_en),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_data      (resp_data),
      .mem_en         (mem_en),
      .mem_wr_en      (mem_wr_en),
      .mem_addr       (mem_addr),
      .mem_wr_data    (mem_wr_data),
      .mem_wr_byte_en (mem_wr_byte_en),
      .mem_rd_data    (mem_rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] sim_rd(input logic [31:0] a);
      return sim_mem.exists(a) ? sim_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   task automatic preload(input logic [31:0] a,
                          input logic [31:0] v);
      sim_mem[a] = v;
      ref_mem[a] = v;
   endtask

   // Memory: write on the edge, read data one cycle later
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr_en)
            sim_mem[mem_addr] = merge(sim_rd(mem_addr),
                                      mem_wr_data,
                                      mem_wr_byte_en);
         else
            mem_rd_data <= sim_rd(mem_addr);
      end
   end

   // Monitor: pop on handshake, push expected on grant
   always @(negedge clk) begin
      if (mon_on) begin
         for (int i = 0; i < 2; i++) begin
            logic [31:0] a;
            logic [31:0] v;
            if (lat_due[i])
               check("resp_latency", 64'(resp_valid[i]), 64'd1);
            if (resp_valid[i] && resp_ready[i]) begin
               if (i == 0) begin
                  if (q0.size() == 0) check("resp0_extra", 64'd1, 64'd0);
                  else check("resp0_data", 64'(resp_data[31:0]),
                             64'(q0.pop_front()));
               end else begin
                  if (q1.size() == 0) check("resp1_extra", 64'd1, 64'd0);
                  else check("resp1_data", 64'(resp_data[63:32]),
                             64'(q1.pop_front()));
               end
            end
            lat_due[i] = req_ready[i];
            if (req_ready[i]) begin
               a = req_addr[i*32 +: 32];
               check("mem_addr", 64'(mem_addr), 64'(a));
               check("mem_we", 64'(mem_wr_en), 64'(req_wr_en[i]));
               if (req_wr_en[i]) begin
                  check("mem_wdata", 64'(mem_wr_data),
                        64'(req_wr_data[i*32 +: 32]));
                  check("mem_be", 64'(mem_wr_byte_en),
                        64'(req_wr_byte_en[i*4 +: 4]));
                  ref_mem[a] = merge(ref_rd(a),
                                     req_wr_data[i*32 +: 32],
                                     req_wr_byte_en[i*4 +: 4]);
                  v = 32'h0;
               end else begin
                  v = ref_rd(a);
               end
               if (i == 0) q0.push_back(v);
               else q1.push_back(v);
            end
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mon_start();
      q0.delete();
      q1.delete();
      lat_due = '0;
      mon_on  = 1'b1;
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      repeat (n) begin
         @(negedge clk);
         nxt();
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      req_valid      = 2'b11;
      req_addr       = '0;
      req_wr_en      = '0;
      req_wr_data    = '0;
      req_wr_byte_en = '0;
      resp_ready     = '0;
      preload(32'h10, 32'h1111_0010);
      preload(32'h20, 32'h2222_0020);
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_data", resp_data, 64'd0);
      check("rst_mem_en", 64'(mem_en), 64'd0);
      check("rst_mem_we", 64'(mem_wr_en), 64'd0);

      // alternating reads from both requesters
      nxt();
      rst_n      = 1'b1;
      resp_ready = 2'b11;
      req_addr   = {32'h20, 32'h10};
      req_wr_en  = 2'b00;
      req_valid  = 2'b11;
      mon_start();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rr_grant", 64'(req_ready),
               (k % 2 == 0) ? 64'd1 : 64'd2);
         nxt();
      end
      idle(2);
      check("q_drain_a", 64'(q0.size() + q1.size()), 64'd0);

      // write by 0 then read back by 1
      req_valid      = 2'b01;
      req_wr_en      = 2'b01;
      req_addr       = {32'h0, 32'h40};
      req_wr_data    = {32'h0, 32'hDEAD_BEEF};
      req_wr_byte_en = 8'h0F;
      @(negedge clk);
      check("wr_grant", 64'(req_ready), 64'd1);
      check("wr_mem_en", 64'(mem_en), 64'd1);
      nxt();
      req_valid = 2'b10;
      req_wr_en = 2'b00;
      req_addr  = {32'h40, 32'h40};
      @(negedge clk);
      check("rd1_grant", 64'(req_ready), 64'd2);
      check("wr_resp_zero", 64'(resp_data[31:0]), 64'd0);
      nxt();
      req_valid = 2'b00;
      @(negedge clk);
      check("rd1_data", 64'(resp_data[63:32]), 64'hDEAD_BEEF);
      nxt();
      idle(1);

      // partial byte-enable write then read back
      preload(32'h50, 32'hAABB_CCDD);
      req_valid      = 2'b01;
      req_wr_en      = 2'b01;
      req_addr       = {32'h0, 32'h50};
      req_wr_data    = {32'h0, 32'h1122_3344};
      req_wr_byte_en = 8'h03;
      @(negedge clk);
      check("be_wr_grant", 64'(req_ready), 64'd1);
      nxt();
      req_wr_en = 2'b00;
      @(negedge clk);
      check("be_rd_regrant", 64'(req_ready), 64'd1);
      nxt();
      req_valid = 2'b00;
      @(negedge clk);
      check("be_rd_data", 64'(resp_data[31:0]), 64'hAABB_3344);
      nxt();
      idle(1);

      // requester 0 back-pressured, requester 1 keeps going
      req_addr   = {32'h20, 32'h10};
      req_wr_en  = 2'b00;
      resp_ready = 2'b10;
      req_valid  = 2'b01;
      @(negedge clk);
      check("bp_grant0", 64'(req_ready), 64'd1);
      nxt();
      req_valid = 2'b11;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_grant1", 64'(req_ready), 64'd2);
         check("bp_valid0", 64'(resp_valid[0]), 64'd1);
         check("bp_hold0", 64'(resp_data[31:0]), 64'h1111_0010);
         nxt();
      end
      resp_ready = 2'b11;
      req_valid  = 2'b00;
      @(negedge clk);
      check("bp_release", 64'(resp_valid[0]), 64'd1);
      nxt();
      @(negedge clk);
      check("bp_empty", 64'(resp_valid), 64'd0);
      nxt();

      // reset with slot 0 in flight and slot 1 full
      resp_ready = 2'b00;
      req_valid  = 2'b10;
      @(negedge clk);
      check("mr_grant1", 64'(req_ready), 64'd2);
      nxt();
      req_valid = 2'b01;
      @(negedge clk);
      check("mr_grant0", 64'(req_ready), 64'd1);
      nxt();
      req_valid = 2'b11;
      @(negedge clk);
      check("mr_busy_valid", 64'(resp_valid), 64'd3);
      check("mr_busy_ready", 64'(req_ready), 64'd0);
      #1;
      mon_on = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("mr_req_ready", 64'(req_ready), 64'd0);
      check("mr_resp_valid", 64'(resp_valid), 64'd0);
      check("mr_resp_data", resp_data, 64'd0);
      check("mr_mem_en", 64'(mem_en), 64'd0);
      check("mr_mem_we", 64'(mem_wr_en), 64'd0);
      nxt();
      nxt();
      rst_n      = 1'b1;
      req_valid  = 2'b00;
      resp_ready = 2'b11;
      mon_start();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("mr_no_stale", 64'(resp_valid), 64'd0);
         nxt();
      end
      req_valid = 2'b11;
      @(negedge clk);
      check("mr_first_grant", 64'(req_ready), 64'd1);
      nxt();
      idle(2);

      // single requester at full rate
      req_valid = 2'b01;
      req_wr_en = 2'b00;
      for (int k = 0; k < 8; k++) begin
         case (k % 3)
            0:       req_addr = {32'h0, 32'h10};
            1:       req_addr = {32'h0, 32'h40};
            default: req_addr = {32'h0, 32'h50};
         endcase
         @(negedge clk);
         check("tp_grant", 64'(req_ready), 64'd1);
         if (k > 0)
            check("tp_resp", 64'(resp_valid[0]), 64'd1);
         nxt();
      end
      idle(2);
      check("q_drain_b", 64'(q0.size() + q1.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
